// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use stalls, branch/jump
// flushes, data-memory freeze with timeout fault, and post-reset init hold.
module pipeline_stall_controller #(
  parameter int INIT_CYCLES = 2,
  parameter int TIMEOUT     = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic [1:0]       pc_src,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             ld_pc,
  output logic             ld_ifid,
  output logic             flush_ifid,
  output logic             clr_idex,
  output logic             ld_pipe,
  output logic             fault,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_WAIT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam int IW = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0]    INIT_LAST = IW'((INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0);
  localparam logic [WW-1:0]    WAIT_MAX  = WW'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam state_t           RST_ST    = (INIT_CYCLES == 0) ? S_RUN : S_INIT;

  state_t          st;
  logic [IW-1:0]   init_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            lu, miss;

  assign state = st;
  assign fault = (st == S_FAULT);

  // A jump redirects the PC regardless of the load, so it never needs the stall.
  assign lu   = idex_mem_read && (idex_rt != 5'd0) && (pc_src != 2'd2) &&
                ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
  assign miss = mem_req && !mem_ready;

  always_comb begin
    ld_pc      = 1'b0;
    ld_ifid    = 1'b0;
    flush_ifid = 1'b0;
    clr_idex   = 1'b0;
    ld_pipe    = 1'b0;
    case (st)
      S_INIT: begin
        clr_idex = 1'b1;
        ld_pipe  = 1'b1;
      end
      S_RUN: begin
        if (miss) begin
          ld_pc = 1'b0;
        end else if (lu) begin
          clr_idex = 1'b1;
          ld_pipe  = 1'b1;
        end else begin
          ld_pc      = 1'b1;
          ld_ifid    = 1'b1;
          ld_pipe    = 1'b1;
          flush_ifid = (pc_src != 2'd0);
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          ld_pc   = 1'b1;
          ld_ifid = 1'b1;
          ld_pipe = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= RST_ST;
      init_cnt  <= '0;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (st)
        S_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == INIT_LAST) st <= S_RUN;
        end
        S_RUN: begin
          if (miss) begin
            wait_cnt <= WW'(1);
            st       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            st       <= S_RUN;
          end else if (wait_cnt == WAIT_MAX) begin
            st <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
      if ((st == S_RUN || st == S_WAIT) && !ld_pc && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_ifid && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Randomized + directed bench for pipeline_stall_controller against a cycle-level
// behavioural model; a second instance with CNT_W=4 exercises counter saturation.
module tb_pipeline_stall_controller;
  localparam int INIT = 2;
  localparam int TO   = 15;

  logic clk = 1'b0, rst = 1'b0;
  logic imr, uses, mreq, mrdy;
  logic [4:0] irt, rs, rt;
  logic [1:0] pcs;
  logic ld_pc, ld_ifid, flush_ifid, clr_idex, ld_pipe, fault;
  logic [1:0] state;
  logic [15:0] stall_cnt, flush_cnt;
  logic s_ld_pc, s_ld_ifid, s_flush_ifid, s_clr_idex, s_ld_pipe, s_fault;
  logic [1:0] s_state;
  logic [3:0] s_stall, s_flush;

  pipeline_stall_controller #(.INIT_CYCLES(INIT), .TIMEOUT(TO), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .idex_mem_read(imr), .idex_rt(irt), .ifid_rs(rs), .ifid_rt(rt),
    .ifid_uses_rt(uses), .pc_src(pcs), .mem_req(mreq), .mem_ready(mrdy),
    .ld_pc(ld_pc), .ld_ifid(ld_ifid), .flush_ifid(flush_ifid), .clr_idex(clr_idex),
    .ld_pipe(ld_pipe), .fault(fault), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipeline_stall_controller #(.INIT_CYCLES(INIT), .TIMEOUT(TO), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .idex_mem_read(imr), .idex_rt(irt), .ifid_rs(rs), .ifid_rt(rt),
    .ifid_uses_rt(uses), .pc_src(pcs), .mem_req(mreq), .mem_ready(mrdy),
    .ld_pc(s_ld_pc), .ld_ifid(s_ld_ifid), .flush_ifid(s_flush_ifid), .clr_idex(s_clr_idex),
    .ld_pipe(s_ld_pipe), .fault(s_fault), .state(s_state), .stall_cnt(s_stall), .flush_cnt(s_flush));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // Model: mode 0 init, 1 run, 2 waiting on memory, 3 faulted; counters unbounded.
  int m_mode, m_init, m_low, m_stall, m_flush;
  bit m_lu, m_miss;
  logic [4:0] m_ctl;  // {ld_pc, ld_ifid, flush_ifid, clr_idex, ld_pipe}
  logic [47:0] got, exp;

  assign got = {ld_pc, ld_ifid, flush_ifid, clr_idex, ld_pipe, fault, state,
                stall_cnt, flush_cnt, s_stall, s_flush};

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_mode = (INIT == 0) ? 1 : 0;
    m_init = 0; m_low = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic predict();
    m_lu   = imr && irt != 0 && pcs != 2 && (irt == rs || (uses && irt == rt));
    m_miss = mreq && !mrdy;
    case (m_mode)
      0: m_ctl = 5'b00011;
      1: m_ctl = m_miss ? 5'b00000 : m_lu ? 5'b00011 : (pcs != 0) ? 5'b11101 : 5'b11001;
      2: m_ctl = mrdy ? 5'b11001 : 5'b00000;
      default: m_ctl = 5'b00000;
    endcase
    exp = {m_ctl, (m_mode == 3), 2'(m_mode), 16'(sat(m_stall, 65535)), 16'(sat(m_flush, 65535)),
           4'(sat(m_stall, 15)), 4'(sat(m_flush, 15))};
  endtask

  task automatic drive(input logic a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] d,
                       input logic e, input logic [1:0] f, input logic g, input logic h);
    imr = a; irt = b; rs = c; rt = d; uses = e; pcs = f; mreq = g; mrdy = h;
    #2;
    predict();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic tick();
    @(posedge clk);
    case (m_mode)
      0: begin m_init++; if (m_init == INIT) m_mode = 1; end
      1: begin
        if (!m_ctl[4]) m_stall++;
        if (m_miss) begin m_mode = 2; m_low = 1; end
        else if (m_ctl[2]) m_flush++;
      end
      2: begin
        if (mrdy) m_mode = 1;
        else begin
          m_stall++; m_low++;
          if (m_low == TO + 1) m_mode = 3;
        end
      end
      default: ;
    endcase
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    idle();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < INIT; i++) begin idle(); tick(); end
  endtask

  task automatic test_reset();
    rst = 1'b0; model_reset(); idle();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_vec got=%h exp=%h", got, exp); end
    checks++;
    if (state !== 2'd0 || fault !== 1'b0 || clr_idex !== 1'b1 || ld_pc !== 1'b0 || stall_cnt !== 16'd0)
      begin errors++; $display("FAIL reset_vals state=%0d fault=%b clr=%b ld_pc=%b stall=%0d exp 0/0/1/0/0",
                               state, fault, clr_idex, ld_pc, stall_cnt); end
    @(posedge clk); #1; rst = 1'b1;
    for (int i = 0; i < INIT; i++) begin
      idle();
      checks++;
      if (got !== exp || ld_pc !== 1'b0 || clr_idex !== 1'b1 || state !== 2'd0)
        begin errors++; $display("FAIL init_hold%0d got=%h exp=%h", i, got, exp); end
      tick();
    end
    idle();
    checks++;
    if (state !== 2'd1 || ld_pc !== 1'b1 || flush_cnt !== 16'd0)
      begin errors++; $display("FAIL init_exit state=%0d ld_pc=%b exp state=1 ld_pc=1", state, ld_pc); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 8, 8, 0, 0, 1, 0, 1);
    checks++;
    if (got !== exp || ld_pc !== 1'b0 || clr_idex !== 1'b1 || flush_ifid !== 1'b0)
      begin errors++; $display("FAIL lu_rs got=%h exp=%h", got, exp); end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (got !== exp || stall_cnt !== 16'd1 || ld_pc !== 1'b1)
      begin errors++; $display("FAIL lu_rt0 stall=%0d ld_pc=%b exp stall=1 ld_pc=1", stall_cnt, ld_pc); end
    tick();
    drive(1, 9, 3, 9, 1, 0, 0, 1);
    checks++;
    if (got !== exp || ld_pc !== 1'b0)
      begin errors++; $display("FAIL lu_rt got=%h exp=%h", got, exp); end
    tick();
    drive(1, 9, 3, 9, 0, 0, 0, 1);
    checks++;
    if (got !== exp || ld_pc !== 1'b1)
      begin errors++; $display("FAIL lu_rt_unused got=%h exp=%h", got, exp); end
    tick();
  endtask

  task automatic test_jump();
    do_reset();
    drive(0, 0, 1, 2, 0, 2, 0, 1);
    checks++;
    if (got !== exp || flush_ifid !== 1'b1 || ld_pc !== 1'b1)
      begin errors++; $display("FAIL jump flush=%b ld_pc=%b exp 1/1", flush_ifid, ld_pc); end
    tick();
    idle();
    checks++;
    if (got !== exp || flush_cnt !== 16'd1 || flush_ifid !== 1'b0)
      begin errors++; $display("FAIL jump_after flush_cnt=%0d flush=%b exp 1/0", flush_cnt, flush_ifid); end
    tick();
    drive(1, 8, 8, 0, 0, 2, 0, 1);
    checks++;
    if (got !== exp || ld_pc !== 1'b1 || flush_ifid !== 1'b1)
      begin errors++; $display("FAIL jump_lu ld_pc=%b flush=%b exp 1/1", ld_pc, flush_ifid); end
    tick();
  endtask

  task automatic test_mem_pass();
    do_reset();
    for (int i = 0; i < TO; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (got !== exp || ld_pc !== 1'b0 || ld_pipe !== 1'b0)
        begin errors++; $display("FAIL mem_frozen%0d got=%h exp=%h", i, got, exp); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    checks++;
    if (got !== exp || ld_pc !== 1'b1 || ld_pipe !== 1'b1 || state !== 2'd2)
      begin errors++; $display("FAIL mem_release got=%h exp=%h", got, exp); end
    tick();
    idle();
    checks++;
    if (got !== exp || state !== 2'd1 || fault !== 1'b0 || stall_cnt !== 16'd15)
      begin errors++; $display("FAIL mem_pass state=%0d fault=%b stall=%0d exp 1/0/15", state, fault, stall_cnt); end
    tick();
  endtask

  task automatic test_mem_fault();
    do_reset();
    for (int i = 0; i <= TO; i++) begin drive(0, 0, 0, 0, 0, 0, 1, 0); tick(); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 1, 1);
      checks++;
      if (got !== exp || state !== 2'd3 || fault !== 1'b1 || ld_pc !== 1'b0 || flush_ifid !== 1'b0)
        begin errors++; $display("FAIL fault_sticky%0d got=%h exp=%h", i, got, exp); end
      tick();
    end
    rst = 1'b0; #1;
    checks++;
    if (state !== 2'd0 || fault !== 1'b0)
      begin errors++; $display("FAIL fault_rst state=%0d fault=%b exp 0/0", state, fault); end
    do_reset();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 2, 3, 1, 1, 0, 1);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL sat_step%0d got=%h exp=%h", i, got, exp); end
      tick();
    end
    idle();
    checks++;
    if (s_flush !== 4'd15 || flush_cnt !== 16'd20)
      begin errors++; $display("FAIL sat_final s_flush=%0d flush=%0d exp 15/20", s_flush, flush_cnt); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (got !== exp || state !== 2'd2)
      begin errors++; $display("FAIL wait_entry state=%0d exp 2", state); end
    rst = 1'b0; #1;
    checks++;
    if (state !== 2'd0 || clr_idex !== 1'b1 || ld_pc !== 1'b0)
      begin errors++; $display("FAIL wait_rst state=%0d clr=%b exp 0/1", state, clr_idex); end
    do_reset();
  endtask

  task automatic test_random();
    int streak = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (streak == 0 && $urandom_range(0, 49) == 0) streak = $urandom_range(10, 20);
      drive($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0, (streak > 0) ? 1'b0 : ($urandom_range(0, 3) != 0));
      if (streak > 0) streak--;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL rand%0d got=%h exp=%h", i, got, exp); end
      tick();
      if ((m_mode == 3 && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) do_reset();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    imr = 0; irt = 0; rs = 0; rt = 0; uses = 0; pcs = 0; mreq = 0; mrdy = 1;
    #1;
    test_reset();
    test_load_use();
    test_jump();
    test_mem_pass();
    test_mem_fault();
    test_saturation();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
